math_sub_48: RTL and testbench
==============================

Name: math_sub_48

Overview:
- Pipelined 48-bit subtractor: dout = dina - dinb, with a 49-bit result carrying borrow or sign.
- Counterpart to the existing 48-bit adder. Used for differencing in the timestamp and correlator paths (TDOA deltas, accumulator deltas).
- Unlike the adder, it carries valid/ready handshakes on both sides, so it can sit between back-pressured stages.
- Carry chain is split across two register stages to meet timing in fabric without a DSP slice.

Parameters:
- SPLIT_STAGE, 1, 1 = two-stage 24/24-bit split (latency 2); 0 = single 48-bit stage (latency 1).
- SIGNED, 0, 0 = operands unsigned, dout[48] is the borrow; 1 = operands two's complement, dout is the sign-extended 49-bit difference.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- ena  in  1  active-high global clock enable; low freezes all state.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- dina  in  48  minuend.
- dinb  in  48  subtrahend.
- out_valid  out  1  dout holds a result.
- out_ready  in  1  downstream accepts dout.
- dout  out  49  difference.
- lt  out  1  dina < dinb (unsigned or signed per SIGNED); qualified by out_valid.
- eq  out  1  dina == dinb; qualified by out_valid.

Behaviour:
- Reset (rst=0 at clk edge): out_valid=0, dout=0, lt=0, eq=0, all internal valid bits 0. in_ready=1 in the first cycle after reset (when ena=1). Reset overrides ena and in-flight data; in-flight results are discarded, never emitted.
- Transfer rules: input transfer when in_valid & in_ready & ena; output transfer when out_valid & out_ready & ena.
- ena=0: no register updates, in_ready=0, out_valid and dout hold their values.
- Stages (SPLIT_STAGE=1):
  - S1 registers lo = {1'b0,dina[23:0]} - {1'b0,dinb[23:0]} (25 bits; bit24 = borrow b1), plus dina[47:24], dinb[47:24] and v1.
  - S2 computes hi = ext(dina[47:24]) - ext(dinb[47:24]) - b1. ext is zero-extension to 25 bits when SIGNED=0 and sign-extension when SIGNED=1.
  - S2 registers dout = {hi[24:0], lo[23:0]}, plus v2 (= out_valid), lt = dout[48], and eq = (lo[23:0]==0) & (hi==0).
- Single stage (SPLIT_STAGE=0): S2 alone, computing the full 49-bit ext(dina) - ext(dinb) in one cycle. Latency 1.
- Arithmetic: dout is exact for all inputs, with no overflow in either mode.
  - Unsigned: dout[48]=1 iff dina<dinb, and dout[47:0] = (dina-dinb) mod 2^48.
  - Signed: dout is in range [-2^48+1, 2^48-1].
- Pipeline advance:
  - S2 loads when (!v2 | out_ready).
  - S1 loads when (!v1 | S2 loads).
  - in_ready = !v1 | S2 loads (combinational from out_ready; permitted).
  - Full throughput of one result per cycle when out_ready=1.
- Bubbles: a stage with no incoming valid clears its v bit when it loads. dout/lt/eq hold their last values while out_valid=0.
- Back-pressure: with out_ready=0 the pipe fills (2 entries in split mode), then in_ready=0. No data loss or duplication.
- Simultaneous output transfer and input transfer on a full pipe: both occur, and the pipe stays full.
- Ordering: strictly in order, no reordering or drops.

Decomposition:
- Shared package math_pkg:
  - MATH_W=48, MATH_SPLIT=24.
  - Typedef for the 49-bit result.
  - Function ext25 (extension of the upper half, parameterised by SIGNED).
- One natural sub-module: math_sub_stage, a generic handshake register slice with payload width parameter, valid/ready, ena and active-low sync reset. It is instantiated once per stage; all arithmetic stays in math_sub_48.

Test Plan:
- Unsigned basic: dina=48'h0000_0000_0010, dinb=48'h0000_0000_0003, out_ready=1 -> after 2 cycles dout=49'h0_0000_0000_000D, lt=0, eq=0, out_valid for 1 cycle.
- Borrow across split (SIGNED=0): dina=48'h0000_0100_0000, dinb=1 -> dout=49'h0_0000_00FF_FFFF. Then dina=0, dinb=1 -> dout=49'h1_FFFF_FFFF_FFFF, lt=1.
- Signed extremes (SIGNED=1): dina=48'h7FFF_FFFF_FFFF, dinb=48'h8000_0000_0000 -> dout=49'h0_FFFF_FFFF_FFFF, lt=0. Swapped operands -> dout=49'h1_0000_0000_0001, lt=1.
- Back-pressure: stream 5 pairs (k, k-1 for k=1..5) with out_ready toggling 1,0,0,1,... -> in_ready drops after 2 pending entries; all 5 outputs equal 1 with eq=0, in order, none lost or duplicated.
- ena/reset: freeze with ena=0 mid-stream for 3 cycles -> no state change, in_ready=0. Then assert rst=0 with 2 entries in flight -> next cycle out_valid=0, dout=0, and no stale result appears afterwards.
- Equal operands: dina=dinb=48'hA5A5_A5A5_A5A5 -> dout=0, eq=1, lt=0. Repeat the test suite with SPLIT_STAGE=0 and check latency 1.

Source files
------------

// File: rtl/math_sub_48_pkg.sv
// math_pkg: shared widths, result type and half-word extension for the math_sub_48 datapath.
package math_pkg;
    localparam int MATH_W     = 48;
    localparam int MATH_SPLIT = 24;

    typedef logic [MATH_W:0] math_res_t;

    function automatic logic [MATH_SPLIT:0] ext25(input logic [MATH_SPLIT-1:0] x, input logic sgn);
        return {sgn & x[MATH_SPLIT-1], x};
    endfunction
endpackage

// File: rtl/math_sub_48_if.sv
// math_sub_48_if: operand/result handshake bundle for math_sub_48.
interface math_sub_48_if;
    import math_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [MATH_W-1:0]   dina;
    logic [MATH_W-1:0]   dinb;
    logic                out_valid;
    logic                out_ready;
    math_res_t           dout;
    logic                lt;
    logic                eq;

    modport master (
        output in_valid, dina, dinb, out_ready,
        input  in_ready, out_valid, dout, lt, eq
    );
    modport slave (
        input  in_valid, dina, dinb, out_ready,
        output in_ready, out_valid, dout, lt, eq
    );
endinterface

// File: rtl/math_sub_48_stage.sv
// math_sub_stage: valid/ready register slice with clock enable and active-low sync reset;
// payload only changes when a valid item is loaded, so it holds through bubbles.
module math_sub_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = ready_o ? valid_i : valid_q;
        data_d  = (ready_o && valid_i) ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ena) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/math_sub_48.sv
// math_sub_48: pipelined 48-bit subtractor giving an exact 49-bit difference plus lt/eq,
// with the borrow chain optionally split 24/24 across two handshake stages.
module math_sub_48
    import math_pkg::*;
#(
    parameter int SPLIT_STAGE = 1,
    parameter int SIGNED      = 0
) (
    input logic          clk,
    input logic          rst,
    input logic          ena,
    math_sub_48_if.slave bus
);
    localparam int S1W = 3 * MATH_SPLIT + 1;
    localparam int S2W = MATH_W + 3;

    logic [MATH_SPLIT:0]   lo_d, lo, hi;
    logic [MATH_SPLIT-1:0] ah, bh;
    logic [S1W-1:0]        s1_d, s1_q;
    logic [S2W-1:0]        s2_d, s2_q;
    math_res_t             diff;
    logic                  s1_rdy, s2_rdy, s2_vin;

    assign lo_d = {1'b0, bus.dina[MATH_SPLIT-1:0]} - {1'b0, bus.dinb[MATH_SPLIT-1:0]};
    assign s1_d = {lo_d, bus.dina[MATH_W-1:MATH_SPLIT], bus.dinb[MATH_W-1:MATH_SPLIT]};

    generate
        if (SPLIT_STAGE != 0) begin : g_split
            math_sub_stage #(.W(S1W)) u_s1 (
                .clk(clk), .rst(rst), .ena(ena),
                .valid_i(bus.in_valid), .data_i(s1_d), .ready_o(s1_rdy),
                .valid_o(s2_vin), .data_o(s1_q), .ready_i(s2_rdy)
            );
        end else begin : g_single
            assign s2_vin = bus.in_valid;
            assign s1_q   = s1_d;
            assign s1_rdy = s2_rdy;
        end
    endgenerate

    assign {lo, ah, bh} = s1_q;
    assign hi   = ext25(ah, SIGNED != 0) - ext25(bh, SIGNED != 0) - {{MATH_SPLIT{1'b0}}, lo[MATH_SPLIT]};
    assign diff = {hi, lo[MATH_SPLIT-1:0]};
    // The difference is exact in 49 bits, so its top bit is the less-than flag in both modes.
    assign s2_d = {diff[MATH_W], (lo[MATH_SPLIT-1:0] == '0) && (hi == '0), diff};

    math_sub_stage #(.W(S2W)) u_s2 (
        .clk(clk), .rst(rst), .ena(ena),
        .valid_i(s2_vin), .data_i(s2_d), .ready_o(s2_rdy),
        .valid_o(bus.out_valid), .data_o(s2_q), .ready_i(bus.out_ready)
    );

    assign {bus.lt, bus.eq, bus.dout} = s2_q;
    assign bus.in_ready = ena && s1_rdy;
endmodule

// File: tb/tb_math_sub_48.sv
// tb_math_sub_48: runs all four SPLIT_STAGE/SIGNED builds on one shared operand stream
// against a wide-integer reference model and a scoreboard per build.
module tb_math_sub_48;
    localparam int N = 211;
    localparam int NLIT = 11;

    typedef struct {
        logic [50:0] exp;
        int          idx;
        int          acc;
    } ent_t;

    logic clk = 1'b0;
    logic rst, ena, ordy, feed, fin;
    int   checks = 0, errors = 0;

    logic [47:0] sa [N];
    logic [47:0] sb [N];
    logic [50:0] lit [2][NLIT];

    always #5 clk = ~clk;

    function automatic logic [50:0] model(input logic [47:0] a, input logic [47:0] b, input int sg);
        longint x, y, d;
        if (sg != 0) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        d = x - y;
        return {x < y, x == y, d[48:0]};
    endfunction

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d got %h want %h", nm, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int SPL = g % 2;
        localparam int SGN = g / 2;
        localparam int LAT = SPL + 1;

        math_sub_48_if bus ();
        math_sub_48 #(.SPLIT_STAGE(SPL), .SIGNED(SGN)) dut (
            .clk(clk), .rst(rst), .ena(ena), .bus(bus)
        );

        ent_t q[$];
        int   idx = 0, n = 0, stall = 0;
        bit   took = 1'b0, prst = 1'b0, pena = 1'b1, fdone = 1'b0;
        logic [50:0] pout;
        logic        pvalid;

        assign bus.out_ready = ordy;

        initial begin
            bus.in_valid = 1'b0;
            bus.dina = '0;
            bus.dinb = '0;
            forever begin
                @(posedge clk);
                #2;
                if (took) idx++;
                bus.in_valid = feed && idx < N;
                if (idx < N) begin
                    bus.dina = sa[idx];
                    bus.dinb = sb[idx];
                end
            end
        end

        always @(negedge clk) begin
            logic [50:0] cur;
            ent_t e;
            cur = {bus.lt, bus.eq, bus.dout};
            took = 1'b0;
            n++;
            if (!rst) begin
                q.delete();
            end else begin
                if (prst) chk("reset_state", g, {bus.out_valid, cur}, 64'd0);
                if (!pena && !prst) chk("ena_hold", g, {bus.out_valid, cur}, {pvalid, pout});
                chk("in_ready", g, bus.in_ready, ena && (q.size() < LAT || bus.out_ready));
                if (q.size() == 0) chk("no_stale", g, bus.out_valid, 1'b0);
                if (bus.out_valid && bus.out_ready && ena && q.size() > 0) begin
                    e = q.pop_front();
                    chk("result", g, cur, e.exp);
                    if (e.idx < NLIT) chk("literal", g, cur, lit[SGN][e.idx]);
                    if (stall <= e.acc) chk("latency", g, n - e.acc, LAT);
                end
                if (bus.in_valid && bus.in_ready && ena) begin
                    q.push_back('{model(bus.dina, bus.dinb, SGN), idx, n});
                    took = 1'b1;
                end
                if (fin && !fdone) begin
                    fdone = 1'b1;
                    chk("drained", g, q.size(), 0);
                end
            end
            if (!ena || !bus.out_ready) stall = n;
            prst = !rst;
            pena = ena;
            pout = cur;
            pvalid = bus.out_valid;
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] r, s;
        rst = 1'b0; ena = 1'b1; ordy = 1'b1; feed = 1'b0; fin = 1'b0;
        sa[0] = 48'h10;             sb[0] = 48'h3;
        sa[1] = 48'h0000_0100_0000; sb[1] = 48'h1;
        sa[2] = 48'h0;              sb[2] = 48'h1;
        sa[3] = 48'h7FFF_FFFF_FFFF; sb[3] = 48'h8000_0000_0000;
        sa[4] = 48'h8000_0000_0000; sb[4] = 48'h7FFF_FFFF_FFFF;
        sa[5] = 48'hA5A5_A5A5_A5A5; sb[5] = 48'hA5A5_A5A5_A5A5;
        for (int k = 0; k < 5; k++) begin
            sa[6+k] = 48'(k + 1);
            sb[6+k] = 48'(k);
        end
        for (int sg = 0; sg < 2; sg++) begin
            lit[sg][0] = {2'b00, 49'hD};
            lit[sg][1] = {2'b00, 49'hFF_FFFF};
            lit[sg][2] = {2'b10, 49'h1_FFFF_FFFF_FFFF};
            lit[sg][5] = {2'b01, 49'h0};
            for (int k = 6; k < NLIT; k++) lit[sg][k] = {2'b00, 49'h1};
        end
        lit[0][3] = {2'b10, 49'h1_FFFF_FFFF_FFFF};
        lit[0][4] = {2'b00, 49'h1};
        lit[1][3] = {2'b00, 49'h0_FFFF_FFFF_FFFF};
        lit[1][4] = {2'b10, 49'h1_0000_0000_0001};
        for (int k = NLIT; k < N; k++) begin
            r = {$urandom, $urandom};
            s = {$urandom, $urandom};
            case ($urandom % 4)
                0: begin sa[k] = r[47:0]; sb[k] = s[47:0]; end
                1: begin sa[k] = r[47:0]; sb[k] = r[47:0]; end
                2: begin sa[k] = r[47:0]; sb[k] = r[47:0] + 48'(s[3:0]) - 48'd8; end
                default: begin sa[k] = {r[47], {23{r[46]}}, r[23:0]}; sb[k] = {s[47], {23{s[46]}}, s[23:0]}; end
            endcase
        end
        for (int sg = 0; sg < 2; sg++)
            for (int k = 0; k < NLIT; k++)
                chk("model_pin", sg, model(sa[k], sb[k], sg), lit[sg][k]);

        step(3);
        rst = 1'b1; feed = 1'b1;
        step(6);
        for (int i = 0; i < 20; i++) begin
            ordy = (i % 3 == 0);
            step(1);
        end
        ordy = 1'b0;
        step(6);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ordy = 1'($urandom % 2);
            step(1);
        end
        ena = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ordy = 1'($urandom % 2);
            step(1);
        end
        ordy = 1'b0;
        step(4);
        rst = 1'b0; feed = 1'b0;
        step(1);
        rst = 1'b1; ordy = 1'b1;
        step(5);
        feed = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ordy = ($urandom % 4) != 0;
            step(1);
        end
        feed = 1'b0; ordy = 1'b1;
        step(10);
        fin = 1'b1;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
